// File: rtl/uart_char_receiver.sv
// UART receiver: turns an asynchronous 8N1 line into one byte per frame with a single-cycle strobe.
// Define UART_CHAR_RECEIVER_PARITY_EN to receive 8E1 frames and enable parity_err_o.
module uart_char_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] char_o,
    output logic       char_valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_CHAR_RECEIVER_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      char_q, char_d;
    logic            cv_q, cv_d;
    logic            fe_q, fe_d;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
    logic            mis_q, mis_d;
    logic            pe_q, pe_d;
`endif

    // rx is asynchronous to clk; both stages idle high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            char_q  <= '0;
            cv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
            mis_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            char_q  <= char_d;
            cv_q    <= cv_d;
            fe_q    <= fe_d;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
            mis_q   <= mis_d;
            pe_q    <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        char_d  = char_q;
        cv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
        mis_d   = mis_q;
        pe_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // mid start bit: a high line here was a glitch, not a frame
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
                        mis_d   = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_CHAR_RECEIVER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_CHAR_RECEIVER_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    mis_d   = ^{rx_s_q, shift_q};
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        fe_d    = 1'b1;
                        state_d = BRK;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
                    end else if (mis_q) begin
                        pe_d    = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        char_d  = shift_q;
                        cv_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign char_o       = char_q;
    assign char_valid_o = cv_q;
    assign frame_err_o  = fe_q;
    assign busy_o       = (state_q != IDLE);
`ifdef UART_CHAR_RECEIVER_PARITY_EN
    assign parity_err_o = pe_q;
`else
    assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_char_receiver.sv
// Self-checking bench for uart_char_receiver: directed scenarios plus random frames
// checked against a frame-level model of strobe timing and content.
module tb_uart_char_receiver;
    localparam int CPB = 16;
`ifdef UART_CHAR_RECEIVER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        int         cyc;
        int         kind;   // 0 valid, 1 frame error, 2 parity error
        logic [7:0] ch;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] char_o;
    logic       char_valid_o, frame_err_o, parity_err_o, busy_o;

    int   cyc = 0;
    int   total = 0, bad = 0;
    int   multi = 0, bad_chg = 0;
    int   last_rise = -1, last_fall = -1;
    logic prev_busy = 1'b0;
    logic [7:0] prev_char = 8'h00;
    logic [7:0] last_char = 8'h00;
    ev_t  got_q[$];
    ev_t  exp_q[$];

    uart_char_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx),
        .char_o       (char_o),
        .char_valid_o (char_valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (int'(char_valid_o) + int'(frame_err_o) + int'(parity_err_o) > 1) multi++;
            e.cyc = cyc;
            e.ch  = char_o;
            if (frame_err_o)       begin e.kind = 1; got_q.push_back(e); end
            else if (parity_err_o) begin e.kind = 2; got_q.push_back(e); end
            else if (char_valid_o) begin e.kind = 0; got_q.push_back(e); end
            if (char_o !== prev_char && !char_valid_o) bad_chg++;
            if (busy_o && !prev_busy) last_rise = cyc;
            if (!busy_o && prev_busy) last_fall = cyc;
        end
        prev_char = char_o;
        prev_busy = busy_o;
    end

    // E0 is three edges after the drive edge; strobe visible the cycle after the stop sample
    function automatic int strobe_at(input int t0);
        return t0 + 3 + CPB / 2 + (PAR ? 10 : 9) * CPB;
    endfunction

    // Caller must be sitting at a posedge; returns at the posedge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit bad_par,
                              output int t0);
        #1 rx = 1'b0;
        t0 = cyc;
        repeat (CPB) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rx = d[k];
            repeat (CPB) @(posedge clk);
        end
        if (PAR) begin
            #1 rx = (^d) ^ bad_par;
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic test_reset;
        int errs = 0;
        #12;
        total++;
        if ({char_valid_o, frame_err_o, parity_err_o, busy_o} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000",
                            {char_valid_o, frame_err_o, parity_err_o, busy_o});
        end
        total++;
        if (char_o !== 8'h00) begin bad++; $display("FAIL reset_char: got %h want 00", char_o); end
        @(negedge clk) rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if ({char_valid_o, frame_err_o, parity_err_o, busy_o} !== 4'b0 || char_o !== 8'h00) errs++;
        end
        total++;
        if (errs !== 0) begin bad++; $display("FAIL idle_quiet: got %0d noisy cycles want 0", errs); end
    endtask

    task automatic test_single;
        int t0;
        got_q.delete();
        @(posedge clk);
        send_frame(8'h56, 1'b1, 1'b0, t0);
        repeat (20) @(posedge clk);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL single_count: got %0d events want 1", got_q.size());
        end else begin
            total++;
            if (got_q[0].kind !== 0 || got_q[0].ch !== 8'h56 || got_q[0].cyc !== strobe_at(t0)) begin
                bad++; $display("FAIL single_ev: got kind=%0d ch=%h cyc=%0d want kind=0 ch=56 cyc=%0d",
                                got_q[0].kind, got_q[0].ch, got_q[0].cyc, strobe_at(t0));
            end
        end
        total++;
        if (last_rise !== t0 + 3 || last_fall !== strobe_at(t0)) begin
            bad++; $display("FAIL single_busy: got rise=%0d fall=%0d want rise=%0d fall=%0d",
                            last_rise, last_fall, t0 + 3, strobe_at(t0));
        end
        total++;
        if (char_o !== 8'h56) begin bad++; $display("FAIL single_char: got %h want 56", char_o); end
        last_char = 8'h56;
    endtask

    task automatic test_glitch;
        int t0;
        got_q.delete();
        @(posedge clk);
        #1 rx = 1'b0;
        t0 = cyc;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_strobe: got %0d events want 0", got_q.size()); end
        total++;
        if (last_rise !== t0 + 3 || last_fall !== t0 + 3 + CPB / 2) begin
            bad++; $display("FAIL glitch_busy: got rise=%0d fall=%0d want rise=%0d fall=%0d",
                            last_rise, last_fall, t0 + 3, t0 + 3 + CPB / 2);
        end
        total++;
        if (char_o !== last_char) begin bad++; $display("FAIL glitch_char: got %h want %h", char_o, last_char); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] msg [8];
        int t0;
        ev_t e;
        msg = '{8'h56, 8'h49, 8'h4B, 8'h48, 8'h59, 8'h41, 8'h54, 8'h48};
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            send_frame(msg[i], 1'b1, 1'b0, t0);
            e.cyc = strobe_at(t0); e.kind = 0; e.ch = msg[i];
            exp_q.push_back(e);
        end
        repeat (20) @(posedge clk);
        last_char = 8'h48;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].kind !== exp_q[i].kind || got_q[i].ch !== exp_q[i].ch) begin
                bad++; $display("FAIL b2b_ev%0d: got cyc=%0d kind=%0d ch=%h want cyc=%0d kind=%0d ch=%h", i,
                                got_q[i].cyc, got_q[i].kind, got_q[i].ch, exp_q[i].cyc, exp_q[i].kind, exp_q[i].ch);
            end
        end
    endtask

    task automatic test_break;
        int t0;
        ev_t e;
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        send_frame(8'h41, 1'b0, 1'b0, t0);
        e.cyc = strobe_at(t0); e.kind = 1; e.ch = last_char;
        exp_q.push_back(e);
        repeat (40 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_frame(8'h42, 1'b1, 1'b0, t0);
        e.cyc = strobe_at(t0); e.kind = 0; e.ch = 8'h42;
        exp_q.push_back(e);
        repeat (20) @(posedge clk);
        last_char = 8'h42;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL break_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].kind !== exp_q[i].kind || got_q[i].ch !== exp_q[i].ch) begin
                bad++; $display("FAIL break_ev%0d: got cyc=%0d kind=%0d ch=%h want cyc=%0d kind=%0d ch=%h", i,
                                got_q[i].cyc, got_q[i].kind, got_q[i].ch, exp_q[i].cyc, exp_q[i].kind, exp_q[i].ch);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int t0;
        d = 8'h48;
        got_q.delete();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rx = d[k];
            if (k == 4) begin
                repeat (CPB / 2) @(posedge clk);
                #2;
                total++;
                if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %b want 1", busy_o); end
                rst = 1'b1;
                #1;
                total++;
                if ({char_o, char_valid_o, frame_err_o, parity_err_o, busy_o} !== 12'h000) begin
                    bad++; $display("FAIL mid_reset_now: got char=%h flags=%b want 00 0000", char_o,
                                    {char_valid_o, frame_err_o, parity_err_o, busy_o});
                end
                repeat (CPB / 2) @(posedge clk);
            end else begin
                repeat (CPB) @(posedge clk);
            end
        end
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (CPB) @(posedge clk);
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL mid_nostrobe: got %0d events want 0", got_q.size()); end
        last_char = 8'h00;
        send_frame(8'h48, 1'b1, 1'b0, t0);
        repeat (20) @(posedge clk);
        total++;
        if (got_q.size() !== 1 || got_q[0].kind !== 0 || got_q[0].ch !== 8'h48 || got_q[0].cyc !== strobe_at(t0)) begin
            bad++; $display("FAIL mid_clean: got n=%0d kind=%0d ch=%h want n=1 kind=0 ch=48", got_q.size(),
                            (got_q.size() > 0) ? got_q[0].kind : -1, (got_q.size() > 0) ? got_q[0].ch : 8'hxx);
        end
        last_char = 8'h48;
        if (PAR) begin
            got_q.delete();
            send_frame(8'h48, 1'b1, 1'b1, t0);
            repeat (20) @(posedge clk);
            total++;
            if (got_q.size() !== 1 || got_q[0].kind !== 2 || char_o !== 8'h48) begin
                bad++; $display("FAIL mid_parity: got n=%0d kind=%0d char=%h want n=1 kind=2 char=48",
                                got_q.size(), (got_q.size() > 0) ? got_q[0].kind : -1, char_o);
            end
        end
    endtask

    task automatic test_random;
        int t0, gap;
        logic [7:0] d;
        bit bp;
        ev_t e;
        got_q.delete();
        exp_q.delete();
        multi = 0;
        bad_chg = 0;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            d   = 8'($urandom_range(0, 255));
            bp  = PAR && ($urandom_range(0, 3) == 0);
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            send_frame(d, 1'b1, bp, t0);
            e.cyc = strobe_at(t0);
            if (bp) begin e.kind = 2; e.ch = last_char; end
            else    begin e.kind = 0; e.ch = d; last_char = d; end
            exp_q.push_back(e);
            repeat (gap) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].kind !== exp_q[i].kind || got_q[i].ch !== exp_q[i].ch) begin
                bad++; $display("FAIL rand_ev%0d: got cyc=%0d kind=%0d ch=%h want cyc=%0d kind=%0d ch=%h", i,
                                got_q[i].cyc, got_q[i].kind, got_q[i].ch, exp_q[i].cyc, exp_q[i].kind, exp_q[i].ch);
            end
        end
        total++;
        if (multi !== 0 || bad_chg !== 0) begin
            bad++; $display("FAIL rand_exclusive: got multi=%0d silent_char_changes=%0d want 0 0", multi, bad_chg);
        end
        total++;
        if (char_o !== last_char) begin bad++; $display("FAIL rand_char: got %h want %h", char_o, last_char); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
